// File: rtl/divsubc_pkg.sv
// ============================================================================
// Module   : divsubc_pkg
// Purpose  : Shared types, default geometry and helpers for the complex
//            divide-after-subtract block (divsubc).
// Contents : state_t   FSM encoding (IDLE, PREP, DIV, DONE)
//            DW_DEF, ACCW_DEF, NW, DENW  default widths
//            sat_apply saturating sign application of a quotient magnitude
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package divsubc_pkg;

   localparam int DW_DEF   = 16;
   localparam int ACCW_DEF = 40;
   // numerator width: (ACCW+1)-bit difference times DW-bit divisor, plus sum carry
   localparam int NW       = ACCW_DEF + DW_DEF + 2;
   localparam int DENW     = 2 * DW_DEF;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PREP = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Applies sign to an unsigned magnitude, or forces the dw-bit signed limit
   // when sat is set. Works on 64 bits so callers of any dw <= 63 truncate.
   function automatic logic [63:0] sat_apply(input logic        neg,
                                             input logic        sat,
                                             input logic [63:0] mag,
                                             input int          dw);
      logic [63:0] maxpos;
      maxpos = (64'd1 << (dw - 1)) - 64'd1;
      if (sat)
         sat_apply = neg ? ~maxpos : maxpos;   // ~maxpos == -(maxpos+1)
      else
         sat_apply = neg ? (~mag + 64'd1) : mag;
   endfunction

endpackage

`default_nettype wire

// File: rtl/divsubc_serdiv.sv
// ============================================================================
// Module   : divsubc_serdiv
// Purpose  : Unsigned restoring divider, one quotient bit per step, MSB first.
//            The caller preloads the partial remainder with the numerator bits
//            above the quotient field (which must already be < den) and the
//            quotient register with the low QW numerator bits; quotient bits
//            shift in from the LSB as numerator bits shift out of the MSB.
// Ports    : clk, rst          clock, synchronous active-high reset
//            load              load rem_init / num_lo
//            step              perform one restoring step
//            rem_init [DEN_W]  initial partial remainder
//            num_lo   [QW]     low numerator bits
//            den      [DEN_W]  divisor (held stable during steps)
//            quo      [QW]     quotient after QW steps
//            rem      [DEN_W]  remainder after QW steps
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module divsubc_serdiv
   import divsubc_pkg::*;
#(
   parameter int DEN_W = DENW,
   parameter int QW    = DW_DEF - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [DEN_W-1:0] rem_init,
   input  logic [QW-1:0]    num_lo,
   input  logic [DEN_W-1:0] den,
   output logic [QW-1:0]    quo,
   output logic [DEN_W-1:0] rem
);

   logic [DEN_W:0]   cand;
   logic [DEN_W-1:0] diff;
   logic             ge;

   assign cand = {rem, quo[QW-1]};
   assign ge   = (cand >= {1'b0, den});
   // when ge holds the true difference is < den, so the low bits are exact
   assign diff = cand[DEN_W-1:0] - den;

   always_ff @(posedge clk) begin
      if (rst) begin
         rem <= '0;
         quo <= '0;
      end else if (load) begin
         rem <= rem_init;
         quo <= num_lo;
      end else if (step) begin
         rem <= ge ? diff : cand[DEN_W-1:0];
         quo <= {quo[QW-2:0], ge};
      end
   end

endmodule

`default_nettype wire

// File: rtl/divsubc.sv
// ============================================================================
// Module   : divsubc
// Purpose  : Recovers a = (y - c) / b for signed complex integers using
//            a = (y-c)*conj(b) / |b|^2, with re and im parts divided in
//            parallel by two restoring dividers. Fixed latency DW+1 edges.
// Config   : DIVSUBC_ROUND_EN  defined -> round half away from zero
//                              undefined -> truncate toward zero
// Ports    : clk, rst              clock, synchronous active-high reset
//            in_valid / in_ready   operand handshake (in_ready only in IDLE)
//            y_re, y_im  [ACCW]    signed accumulator value
//            c_re, c_im  [ACCW]    signed offset subtracted from y
//            b_re, b_im  [DW]      signed complex divisor
//            out_valid / out_ready result handshake
//            a_re, a_im  [DW]      signed complex quotient
//            ovf                   a part saturated
//            div0                  divisor was zero
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module divsubc
   import divsubc_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int ACCW = ACCW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [ACCW-1:0] y_re,
   input  logic [ACCW-1:0] y_im,
   input  logic [ACCW-1:0] c_re,
   input  logic [ACCW-1:0] c_im,
   input  logic [DW-1:0]   b_re,
   input  logic [DW-1:0]   b_im,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   a_re,
   output logic [DW-1:0]   a_im,
   output logic            ovf,
   output logic            div0
);

   localparam int NUM_W = ACCW + DW + 2;
   localparam int DEN_W = 2 * DW;
   localparam int QW    = DW - 1;
   localparam int CW    = $clog2(DW);

   state_t                 state;
   logic [CW-1:0]          cnt;

   logic [ACCW-1:0]        op_y_re, op_y_im, op_c_re, op_c_im;
   logic [DW-1:0]          op_b_re, op_b_im;

   logic [DEN_W-1:0]       den;
   logic                   neg_re, neg_im;
   logic                   ovf_pre_re, ovf_pre_im;
   logic                   den_zero;

   // ---------------------------------------------------------------- PREP math
   logic signed [ACCW:0]       d_re, d_im;
   logic signed [NUM_W-1:0]    dx_re, dx_im, bx_re, bx_im;
   logic signed [NUM_W-1:0]    num_re, num_im;
   logic signed [DEN_W-1:0]    bs_re, bs_im, sq_re, sq_im;
   logic [DEN_W-1:0]           den_c;
   logic [NUM_W-1:0]           mag_re, mag_im, den_sh;
   logic                       ovf_c_re, ovf_c_im;

   // one extra bit so y - c never wraps
   assign d_re  = {op_y_re[ACCW-1], op_y_re} - {op_c_re[ACCW-1], op_c_re};
   assign d_im  = {op_y_im[ACCW-1], op_y_im} - {op_c_im[ACCW-1], op_c_im};

   assign dx_re = {{(NUM_W-ACCW-1){d_re[ACCW]}}, d_re};
   assign dx_im = {{(NUM_W-ACCW-1){d_im[ACCW]}}, d_im};
   assign bx_re = {{(NUM_W-DW){op_b_re[DW-1]}}, op_b_re};
   assign bx_im = {{(NUM_W-DW){op_b_im[DW-1]}}, op_b_im};

   // (y-c) * conj(b)
   assign num_re = dx_re * bx_re + dx_im * bx_im;
   assign num_im = dx_im * bx_re - dx_re * bx_im;

   assign bs_re  = {{DW{op_b_re[DW-1]}}, op_b_re};
   assign bs_im  = {{DW{op_b_im[DW-1]}}, op_b_im};
   assign sq_re  = bs_re * bs_re;
   assign sq_im  = bs_im * bs_im;
   // up to 2^(2*DW-1): fits only as unsigned
   assign den_c  = sq_re + sq_im;

   assign mag_re = num_re[NUM_W-1] ? -num_re : num_re;
   assign mag_im = num_im[NUM_W-1] ? -num_im : num_im;

   // quotient magnitude >= 2^(DW-1) cannot be represented
   assign den_sh   = {{(NUM_W-DEN_W-QW){1'b0}}, den_c, {QW{1'b0}}};
   assign ovf_c_re = (mag_re >= den_sh);
   assign ovf_c_im = (mag_im >= den_sh);

   // ----------------------------------------------------------------- dividers
   logic             div_load, div_step;
   logic [QW-1:0]    q_re, q_im;
   logic [DEN_W-1:0] rem_re, rem_im;

   assign div_load = (state == S_PREP);
   assign div_step = (state == S_DIV);

   divsubc_serdiv #(.DEN_W(DEN_W), .QW(QW)) u_div_re (
      .clk      (clk),
      .rst      (rst),
      .load     (div_load),
      .step     (div_step),
      .rem_init (mag_re[QW +: DEN_W]),
      .num_lo   (mag_re[QW-1:0]),
      .den      (den),
      .quo      (q_re),
      .rem      (rem_re)
   );

   divsubc_serdiv #(.DEN_W(DEN_W), .QW(QW)) u_div_im (
      .clk      (clk),
      .rst      (rst),
      .load     (div_load),
      .step     (div_step),
      .rem_init (mag_im[QW +: DEN_W]),
      .num_lo   (mag_im[QW-1:0]),
      .den      (den),
      .quo      (q_im),
      .rem      (rem_im)
   );

   // ------------------------------------------------------------- finalisation
   logic [DW-1:0] mag_fin_re, mag_fin_im;
   logic          sat_re, sat_im;

`ifdef DIVSUBC_ROUND_EN
   logic [DEN_W:0] rem2_re, rem2_im;
   logic           rnd_re, rnd_im;

   assign rem2_re    = {rem_re, 1'b0};
   assign rem2_im    = {rem_im, 1'b0};
   assign rnd_re     = (rem2_re >= {1'b0, den});
   assign rnd_im     = (rem2_im >= {1'b0, den});
   assign mag_fin_re = {1'b0, q_re} + DW'(rnd_re);
   assign mag_fin_im = {1'b0, q_im} + DW'(rnd_im);
   // a rounded magnitude of 2^(DW-1) is still legal when negative
   assign sat_re     = ovf_pre_re | (~neg_re & mag_fin_re[DW-1]);
   assign sat_im     = ovf_pre_im | (~neg_im & mag_fin_im[DW-1]);
`else
   logic unused_rem;

   assign mag_fin_re = {1'b0, q_re};
   assign mag_fin_im = {1'b0, q_im};
   assign sat_re     = ovf_pre_re;
   assign sat_im     = ovf_pre_im;
   assign unused_rem = ^{rem_re, rem_im};
`endif

   // --------------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         in_ready   <= 1'b0;
         out_valid  <= 1'b0;
         a_re       <= '0;
         a_im       <= '0;
         ovf        <= 1'b0;
         div0       <= 1'b0;
         op_y_re    <= '0;
         op_y_im    <= '0;
         op_c_re    <= '0;
         op_c_im    <= '0;
         op_b_re    <= '0;
         op_b_im    <= '0;
         den        <= '0;
         neg_re     <= 1'b0;
         neg_im     <= 1'b0;
         ovf_pre_re <= 1'b0;
         ovf_pre_im <= 1'b0;
         den_zero   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  op_y_re  <= y_re;
                  op_y_im  <= y_im;
                  op_c_re  <= c_re;
                  op_c_im  <= c_im;
                  op_b_re  <= b_re;
                  op_b_im  <= b_im;
                  in_ready <= 1'b0;
                  state    <= S_PREP;
               end
            end
            S_PREP: begin
               den        <= den_c;
               neg_re     <= num_re[NUM_W-1];
               neg_im     <= num_im[NUM_W-1];
               ovf_pre_re <= ovf_c_re;
               ovf_pre_im <= ovf_c_im;
               den_zero   <= (den_c == '0);
               cnt        <= '0;
               state      <= S_DIV;
            end
            S_DIV: begin
               cnt <= cnt + CW'(1);
               if (cnt == CW'(QW - 1))
                  state <= S_DONE;
            end
            S_DONE: begin
               // first DONE cycle registers the result; later cycles wait
               if (!out_valid) begin
                  a_re      <= den_zero ? '0 :
                               DW'(sat_apply(neg_re, sat_re, 64'(mag_fin_re), DW));
                  a_im      <= den_zero ? '0 :
                               DW'(sat_apply(neg_im, sat_im, 64'(mag_fin_im), DW));
                  ovf       <= ~den_zero & (sat_re | sat_im);
                  div0      <= den_zero;
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
